ram_responder: RTL and testbench

- Behavioural RAM responder at the far end of the memory controller's RAM port.
- Accepts the controller's ramREN/ramWEN/ramaddr/ramstore requests, models fixed access latency, and reports progress on ramstate (FREE/BUSY/ACCESS/ERROR from cpu_types_pkg).
- Returns read data on ramload and commits writes.
- Used as the RAM in single-core and multicore simulation benches.

---
 rtl/ram_responder.sv | 116 +++++++++++
 tb/tb_ram_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// Behavioural RAM at the far end of the memory controller's RAM port.
// Fixed-latency access with ramstate progress reporting and error detection.
`timescale 1ns/1ps
module ram_responder #(
    parameter int LAT      = 2,
    parameter int MEMWORDS = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    localparam int AW = $clog2(MEMWORDS);

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, WAIT, ACC, ERR} state_t;

    state_t      state;
    state_t      cap_state;
    logic [3:0]  cnt;
    logic [3:0]  cap_cnt;
    logic        op_wr;
    logic [31:0] addr;
    logic        req;
    logic        bad;
    logic        changed;
    logic [31:0] mem [MEMWORDS];

    always_comb begin
        req     = ramREN | ramWEN;
        bad     = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00)
                | (|ramaddr[31:AW+2]);
        changed = (ramREN & ramWEN) | (ramWEN != op_wr)
                | (ramaddr != addr);
        cap_cnt = 4'(LAT - 1);
        if (bad)
            cap_state = ERR;
        else if (LAT == 1)
            cap_state = ACC;
        else
            cap_state = WAIT;
    end

    always_comb begin
        ramstate = FREE;
        unique case (state)
            IDLE: ramstate = FREE;
            WAIT: ramstate = BUSY;
            ACC:  ramstate = ACCESS;
            ERR:  ramstate = ERROR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            ramload <= '0;
            op_wr   <= 1'b0;
            addr    <= '0;
            for (int i = 0; i < MEMWORDS; i++)
                mem[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        op_wr <= ramWEN;
                        addr  <= ramaddr;
                        cnt   <= cap_cnt;
                        state <= cap_state;
                        // LAT==1 enters ACC straight from capture
                        if (cap_state == ACC && !ramWEN)
                            ramload <= mem[ramaddr[AW+1:2]];
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (changed) begin
                        op_wr <= ramWEN;
                        addr  <= ramaddr;
                        cnt   <= cap_cnt;
                        state <= cap_state;
                        if (cap_state == ACC && !ramWEN)
                            ramload <= mem[ramaddr[AW+1:2]];
                    end else if (cnt == 4'd1) begin
                        cnt   <= '0;
                        state <= ACC;
                        if (!op_wr)
                            ramload <= mem[addr[AW+1:2]];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACC: begin
                    if (op_wr)
                        mem[addr[AW+1:2]] <= ramstore;
                    state <= IDLE;
                end
                ERR: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: LAT=2 and LAT=1 builds driven by shared stimulus,
// checked every cycle against a transaction-level model plus directed literals.
`timescale 1ns/1ps
module tb_ram_responder;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;
    localparam int MW = 1024;

    logic        CLK;
    logic        RST;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ld_a, ld_b;
    logic [1:0]  st_a, st_b;

    int checks = 0;
    int errors = 0;

    ram_responder #(.LAT(2), .MEMWORDS(MW)) dut (
        .CLK(CLK), .RST(RST), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ld_a), .ramstate(st_a)
    );

    ram_responder #(.LAT(1), .MEMWORDS(MW)) dut1 (
        .CLK(CLK), .RST(RST), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ld_b), .ramstate(st_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: per build, a request is aged from capture; ACCESS at age==LAT.
    int          lat_of [2] = '{2, 1};
    logic [31:0] mm     [2][MW];
    bit          pend   [2];
    bit          in_acc [2];
    bit          in_err [2];
    bit          mwr    [2];
    int          age    [2];
    logic [31:0] madr   [2];
    logic [31:0] mload  [2];
    bit          mvalid = 0;

    function automatic bit is_bad(logic r, logic w, logic [31:0] a);
        return (r && w) || (a[1:0] != 2'b00) || (int'(a[31:2]) >= MW)
            || (a[31:2] >= 30'(MW));
    endfunction

    task automatic complete(int k);
        pend[k]   = 0;
        in_acc[k] = 1;
        if (!mwr[k])
            mload[k] = mm[k][int'(madr[k][31:2])];
    endtask

    task automatic capture(int k);
        mwr[k]  = ramWEN;
        madr[k] = ramaddr;
        age[k]  = 1;
        pend[k] = 0;
        if (is_bad(ramREN, ramWEN, ramaddr))
            in_err[k] = 1;
        else if (age[k] >= lat_of[k])
            complete(k);
        else
            pend[k] = 1;
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (RST) begin
                pend[k] = 0; in_acc[k] = 0; in_err[k] = 0;
                mwr[k] = 0; madr[k] = 0; mload[k] = 0; age[k] = 0;
                for (int i = 0; i < MW; i++) mm[k][i] = 0;
            end else if (in_acc[k]) begin
                if (mwr[k]) mm[k][int'(madr[k][31:2])] = ramstore;
                in_acc[k] = 0;
            end else if (in_err[k]) begin
                in_err[k] = 0;
            end else if (pend[k]) begin
                if (!(ramREN || ramWEN))
                    pend[k] = 0;
                else if ((ramREN && ramWEN) || ramWEN != mwr[k]
                         || ramaddr != madr[k])
                    capture(k);
                else begin
                    age[k]++;
                    if (age[k] == lat_of[k]) complete(k);
                end
            end else if (ramREN || ramWEN) begin
                capture(k);
            end
        end
        if (RST) mvalid = 1;
    endtask

    function automatic logic [1:0] exp_st(int k);
        if (in_acc[k]) return ACCESS;
        if (in_err[k]) return ERROR;
        if (pend[k])   return BUSY;
        return FREE;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    initial forever begin
        @(negedge CLK);
        if (mvalid) begin
            chk("state_lat2", 32'(st_a), 32'(exp_st(0)));
            chk("load_lat2",  ld_a, mload[0]);
            chk("state_lat1", 32'(st_b), 32'(exp_st(1)));
            chk("load_lat1",  ld_b, mload[1]);
        end
    end

    task automatic wait_done(output int n, output logic [1:0] fin);
        n = 0;
        fin = FREE;
        while (n < 20) begin
            @(negedge CLK);
            n++;
            if (st_a == ACCESS || st_a == ERROR) begin
                fin = st_a;
                break;
            end
        end
    endtask

    task automatic access(input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          output int n, output logic [1:0] fin);
        ramREN = r; ramWEN = w; ramaddr = a; ramstore = d;
        wait_done(n, fin);
    endtask

    task automatic idle(int n);
        ramREN = 0; ramWEN = 0;
        repeat (n) @(negedge CLK);
    endtask

    int         n;
    logic [1:0] fin;

    initial begin
        RST = 1; ramREN = 0; ramWEN = 0; ramaddr = 0; ramstore = 0;
        repeat (2) @(negedge CLK);
        RST = 0;

        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("idle_state", 32'(st_a), 32'(FREE));
            chk("idle_load", ld_a, 32'h0);
        end
        access(1, 0, 32'h0, 32'h0, n, fin);
        chk("rd0_lat", n, 2);
        chk("rd0_load", ld_a, 32'h0);
        idle(2);

        access(0, 1, 32'h10, 32'hDEADBEEF, n, fin);
        chk("wr10_lat", n, 2);
        access(1, 0, 32'h10, 32'hDEADBEEF, n, fin);
        chk("rd10_lat", n, 3);
        chk("rd10_load", ld_a, 32'hDEADBEEF);
        idle(2);

        access(0, 1, 32'h20, 32'hA0A0A0A0, n, fin);
        access(0, 1, 32'h24, 32'hB1B1B1B1, n, fin);
        access(0, 1, 32'h28, 32'hC2C2C2C2, n, fin);
        idle(3);
        ramREN = 1; ramaddr = 32'h20;
        @(negedge CLK);
        chk("chg_busy0", 32'(st_a), 32'(BUSY));
        ramaddr = 32'h24;
        @(negedge CLK);
        chk("chg_busy1", 32'(st_a), 32'(BUSY));
        ramaddr = 32'h28;
        wait_done(n, fin);
        chk("chg_lat", n, 2);
        chk("chg_load", ld_a, 32'hC2C2C2C2);
        idle(3);

        access(1, 1, 32'h0, 32'h12345678, n, fin);
        chk("both_n", n, 1);
        chk("both_err", 32'(fin), 32'(ERROR));
        idle(1);
        chk("both_free", 32'(st_a), 32'(FREE));
        idle(2);
        access(1, 0, 32'h0, 32'h0, n, fin);
        chk("mem0_kept", ld_a, 32'h0);
        idle(2);
        access(1, 0, 32'h3, 32'h0, n, fin);
        chk("misalign_err", 32'(fin), 32'(ERROR));
        idle(2);
        access(0, 1, 32'(MW * 4), 32'h1, n, fin);
        chk("range_err", 32'(fin), 32'(ERROR));
        chk("range_n", n, 1);
        idle(2);

        ramWEN = 1; ramaddr = 32'h40; ramstore = 32'h77777777;
        @(negedge CLK);
        chk("rst_busy", 32'(st_a), 32'(BUSY));
        RST = 1;
        @(negedge CLK);
        chk("rst_free", 32'(st_a), 32'(FREE));
        RST = 0;
        idle(1);
        access(1, 0, 32'h40, 32'h0, n, fin);
        chk("rst_rd_lat", n, 2);
        chk("rst_rd_load", ld_a, 32'h0);
        chk("rst_rd10", mload[0], 32'h0);
        idle(3);

        ramREN = 1; ramaddr = 32'h8;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            chk("lat1_alt", 32'(st_b), (k % 2) ? 32'(ACCESS) : 32'(FREE));
        end
        idle(3);

        for (int s = 0; s < 800; s++) begin
            int r = $urandom_range(0, 9);
            if ($urandom_range(0, 149) == 0) begin
                RST = 1;
                @(negedge CLK);
                RST = 0;
            end
            if (r < 2) begin
                idle($urandom_range(1, 3));
            end else begin
                int op = $urandom_range(0, 19);
                int ak = $urandom_range(0, 19);
                int hold = $urandom_range(1, 6);
                ramREN = (op < 9) || (op >= 18);
                ramWEN = (op >= 9);
                if (ak == 0)
                    ramaddr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                else if (ak == 1)
                    ramaddr = 32'($urandom_range(MW, MW + 500) * 4);
                else
                    ramaddr = 32'($urandom_range(0, 15) * 4);
                for (int h = 0; h < hold; h++) begin
                    ramstore = $urandom;
                    @(negedge CLK);
                end
            end
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
